// File: rtl/countdown60_pkg.sv
// Shared timer definitions: FSM state encodings, BCD digit limits and BCD helpers.
// Used by countdown60 and its up-counting sibling.
package countdown60_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] UNIT_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    // Out-of-range digits saturate to the largest legal digit.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = (v[7:4] > TENS_MAX) ? TENS_MAX : v[7:4];
        units = (v[3:0] > UNIT_MAX) ? UNIT_MAX : v[3:0];
        return {tens, units};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, UNIT_MAX};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown60_key_debounce.sv
// Key conditioning: 2-FF synchroniser, stability debounce and a single-cycle press pulse.
// Keys are active-low; a held key produces one pulse and must be released stably to re-arm.
module countdown60_key_debounce #(
    parameter int DEBOUNCE_CYC = 240_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

    logic          key_meta;
    logic          key_sync;
    logic          key_stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta   <= 1'b1;
            key_sync   <= 1'b1;
            key_stable <= 1'b1;
            cnt        <= RELOAD;
            press      <= 1'b0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
            press    <= 1'b0;
            // Down-counter reloads on any sample matching the accepted level,
            // so only an unbroken run of DEBOUNCE_CYC differing samples commits.
            if (key_sync == key_stable) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                key_stable <= key_sync;
                press      <= ~key_sync;
                cnt        <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown60_seg.sv
// Board segment decoder for the two-digit display, one instance drives both digits.
// Output format {SEG,DP,G..A}: SEG=0 enables the digit, DP off, segments active-high.
module countdown60_seg (
    input  logic [7:0] bcd,
    output logic [8:0] seg_tens,
    output logic [8:0] seg_units
);

    function automatic logic [8:0] seg_of(input logic [3:0] d);
        logic [8:0] s;
        case (d)
            4'd0:    s = 9'h03F;
            4'd1:    s = 9'h006;
            4'd2:    s = 9'h05B;
            4'd3:    s = 9'h04F;
            4'd4:    s = 9'h066;
            4'd5:    s = 9'h06D;
            4'd6:    s = 9'h07D;
            4'd7:    s = 9'h007;
            4'd8:    s = 9'h07F;
            4'd9:    s = 9'h06F;
            default: s = 9'h000;
        endcase
        return s;
    endfunction

    assign seg_tens  = seg_of(bcd[7:4]);
    assign seg_units = seg_of(bcd[3:0]);

endmodule

// File: rtl/countdown60.sv
// Two-digit BCD countdown timer (59..00) with start/pause and load keys.
// Define AUTO_RELOAD_EN to reload the preset after reaching 00 instead of stopping.
//
// state | meaning
// IDLE  | preset loaded, waiting for start
// RUN   | prescaler running, count decrements once per tick
// PAUSE | prescaler and count frozen, start resumes
// DONE  | reached 00, done held until load or rst
module countdown60
    import countdown60_pkg::*;
#(
    parameter int         TICK_DIV       = 12_000_000,
    parameter int         DEBOUNCE_CYC   = 240_000,
    parameter logic [7:0] DEFAULT_PRESET = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_load,
    input  logic [7:0] preset,
    output logic [7:0] count_bcd,
    output logic       running,
    output logic       done,
    output logic [8:0] segment_led_1,
    output logic [8:0] segment_led_2
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    count_q;
    logic [7:0]    count_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          start_p;
    logic          load_p;
    logic          tick;
    logic          done_pulse;
    logic [7:0]    preset_c;

    countdown60_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_start (
        .clk   (clk),
        .rst   (rst),
        .key   (key_start),
        .press (start_p)
    );

    countdown60_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_load (
        .clk   (clk),
        .rst   (rst),
        .key   (key_load),
        .press (load_p)
    );

    assign preset_c = bcd_clamp(preset);
    assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        presc_d    = presc_q;
        done_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_p) begin
                    count_d = preset_c;
                    presc_d = '0;
                end else if (start_p && (count_q != 8'h00)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
`ifdef AUTO_RELOAD_EN
                    if (count_q == 8'h00) begin
                        count_d = preset_c;
                        if (preset_c == 8'h00) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d    = bcd_dec(count_q);
                        done_pulse = (count_q == 8'h01);
                    end
`else
                    count_d = bcd_dec(count_q);
                    if (count_q == 8'h01) begin
                        state_d = ST_DONE;
                    end
`endif
                end
                // Reaching DONE takes priority over a coincident pause request.
                if (start_p && (state_d == ST_RUN)) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (load_p) begin
                    count_d = preset_c;
                    presc_d = '0;
                    state_d = ST_IDLE;
                end else if (start_p) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load_p) begin
                    count_d = preset_c;
                    presc_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= DEFAULT_PRESET;
            presc_q <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            running <= (state_d == ST_RUN);
            done    <= (state_d == ST_DONE) || done_pulse;
        end
    end

    assign count_bcd = count_q;

    countdown60_seg u_seg (
        .bcd       (count_q),
        .seg_tens  (segment_led_1),
        .seg_units (segment_led_2)
    );

endmodule

// File: tb/tb_countdown60.sv
// Directed bench for countdown60 with TICK_DIV=4, DEBOUNCE_CYC=3.
// Compile with AUTO_RELOAD_EN defined to exercise the reload variant.
module tb_countdown60;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_load;
    logic [7:0] preset;
    logic [7:0] count_bcd;
    logic       running;
    logic       done;
    logic [8:0] segment_led_1;
    logic [8:0] segment_led_2;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    countdown60 #(
        .TICK_DIV       (4),
        .DEBOUNCE_CYC   (3),
        .DEFAULT_PRESET (8'h59)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_start     (key_start),
        .key_load      (key_load),
        .preset        (preset),
        .count_bcd     (count_bcd),
        .running       (running),
        .done          (done),
        .segment_led_1 (segment_led_1),
        .segment_led_2 (segment_led_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_change(input int budget, output int edge_at, output logic ok);
        logic [7:0] prev;
        int         i;
        prev    = count_bcd;
        ok      = 1'b0;
        edge_at = cyc;
        i       = 0;
        while (!ok && i < budget) begin
            @(negedge clk);
            i++;
            if (count_bcd != prev) begin
                ok      = 1'b1;
                edge_at = cyc;
            end
        end
    endtask

    task automatic wait_running(input logic val, input int budget, output int edge_at, output logic ok);
        int i;
        ok      = 1'b0;
        edge_at = cyc;
        i       = 0;
        while (!ok && i < budget) begin
            @(negedge clk);
            i++;
            if (running == val) begin
                ok      = 1'b1;
                edge_at = cyc;
            end
        end
    endtask

    task automatic press_load();
        key_load = 1'b0;
        tick_n(10);
        key_load = 1'b1;
        tick_n(10);
    endtask

    // Press start, wait for running to reach val, release and let the key settle.
    task automatic toggle_start(input string tag, input logic val, output int edge_at);
        logic ok;
        key_start = 1'b0;
        wait_running(val, 15, edge_at, ok);
        chk(tag, ok, 1'b1);
        key_start = 1'b1;
    endtask

    logic [7:0] seq_a [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    initial begin
        int         e_prev;
        int         e_now;
        int         e_p;
        int         e_r;
        int         k;
        logic       ok;
        logic       bad;
        logic [7:0] held;
        logic [7:0] exp_c;

        rst       = 1'b1;
        key_start = 1'b1;
        key_load  = 1'b1;
        preset    = 8'h00;
        tick_n(2);
        rst = 1'b0;
        chk("rst_count", count_bcd, 8'h59);
        chk("rst_running", running, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_seg_tens", segment_led_1, 9'h06D);
        chk("rst_seg_units", segment_led_2, 9'h06F);

        // Count down 12 -> 00, one step every 4 cycles.
        preset = 8'h12;
        press_load();
        chk("load_12", count_bcd, 8'h12);
        toggle_start("start_run", 1'b1, e_prev);
        for (int i = 0; i < 12; i++) begin
            wait_change(8, e_now, ok);
            chk("seq_timeout", ok, 1'b1);
            chk("seq_value", count_bcd, seq_a[i]);
            chk("seq_period", e_now - e_prev, 4);
            if (seq_a[i] == 8'h09) begin
                chk("seq_seg_tens_0", segment_led_1, 9'h03F);
                chk("seq_seg_units_9", segment_led_2, 9'h06F);
            end
            e_prev = e_now;
        end
`ifndef AUTO_RELOAD_EN
        chk("end_done", done, 1'b1);
        chk("end_running", running, 1'b0);
        tick_n(20);
        chk("end_done_held", done, 1'b1);
        chk("end_count_held", count_bcd, 8'h00);
`else
        chk("end_done_pulse", done, 1'b1);
        tick_n(1);
        chk("end_done_pulse_1cyc", done, 1'b0);
        chk("end_still_running", running, 1'b1);
        key_start = 1'b0;
        wait_running(1'b0, 15, e_now, ok);
        chk("pause_auto", ok, 1'b1);
        key_start = 1'b1;
        tick_n(10);
`endif

        // Bouncing start key yields one press; holding it never repeats.
        preset = 8'h59;
        press_load();
        chk("reload_59", count_bcd, 8'h59);
        chk("reload_done_clear", done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            key_start = (i % 2 == 1);
            tick_n(1);
        end
        key_start = 1'b0;
        wait_running(1'b1, 15, e_now, ok);
        chk("bounce_one_press", ok, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick_n(1);
            if (running !== 1'b1) bad = 1'b1;
        end
        chk("hold_no_repeat", bad, 1'b0);
        key_start = 1'b1;
        tick_n(10);

        // Load while running is ignored.
        preset = 8'h05;
        press_load();
        chk("load_in_run_running", running, 1'b1);
        chk("load_in_run_ignored", (count_bcd == 8'h05), 1'b0);

        // Pause part-way through a second, then resume the remainder.
        toggle_start("pause_1", 1'b0, e_now);
        tick_n(10);
        press_load();
        chk("load_05", count_bcd, 8'h05);
        toggle_start("start_05", 1'b1, e_prev);
        wait_change(8, e_now, ok);
        chk("first_05_timeout", ok, 1'b1);
        chk("first_05_value", count_bcd, 8'h04);
        chk("first_05_period", e_now - e_prev, 4);
        key_start = 1'b0;
        wait_running(1'b0, 15, e_p, ok);
        chk("pause_2", ok, 1'b1);
        k     = (e_p - e_now) % 4;
        exp_c = 8'h04 - 8'((e_p - e_now) / 4);
        chk("pause_count", count_bcd, exp_c);
        tick_n(5);
        key_start = 1'b1;
        held = count_bcd;
        tick_n(12);
        chk("paused_frozen", count_bcd, held);
        chk("paused_running", running, 1'b0);
        toggle_start("resume", 1'b1, e_r);
        wait_change(8, e_now, ok);
        chk("resume_timeout", ok, 1'b1);
        chk("resume_remainder", e_now - e_r, 4 - k);
        chk("resume_value", count_bcd, exp_c - 8'h01);

        // Clamp of an out-of-range preset.
        toggle_start("pause_3", 1'b0, e_now);
        tick_n(10);
        preset = 8'hAF;
        press_load();
        chk("clamp_AF", count_bcd, 8'h59);
        chk("clamp_idle", running, 1'b0);

        // Start and load together from PAUSE: load wins.
        toggle_start("run_4", 1'b1, e_now);
        tick_n(10);
        toggle_start("pause_4", 1'b0, e_now);
        tick_n(10);
        preset    = 8'h23;
        key_start = 1'b0;
        key_load  = 1'b0;
        tick_n(12);
        key_start = 1'b1;
        key_load  = 1'b1;
        tick_n(10);
        chk("both_count", count_bcd, 8'h23);
        chk("both_running", running, 1'b0);
        chk("both_done", done, 1'b0);

        // Start at 00 stays in IDLE.
        preset = 8'h00;
        press_load();
        chk("load_00", count_bcd, 8'h00);
        key_start = 1'b0;
        tick_n(12);
        key_start = 1'b1;
        tick_n(10);
        chk("start_at_00", running, 1'b0);
        chk("start_at_00_done", done, 1'b0);

`ifdef AUTO_RELOAD_EN
        preset = 8'h02;
        press_load();
        toggle_start("auto_start", 1'b1, e_prev);
        for (int i = 0; i < 5; i++) begin
            wait_change(8, e_now, ok);
            chk("auto_timeout", ok, 1'b1);
            chk("auto_period", e_now - e_prev, 4);
            chk("auto_running", running, 1'b1);
            case (i % 3)
                0: chk("auto_value", count_bcd, 8'h01);
                1: chk("auto_value", count_bcd, 8'h00);
                default: chk("auto_value", count_bcd, 8'h02);
            endcase
            chk("auto_done", done, (i % 3 == 1));
            e_prev = e_now;
        end
        toggle_start("auto_pause", 1'b0, e_now);
        tick_n(10);
`endif

        // Reset mid-count overrides everything.
        preset = 8'h30;
        press_load();
        toggle_start("run_rst", 1'b1, e_now);
        wait_change(8, e_now, ok);
        chk("run_rst_timeout", ok, 1'b1);
        rst = 1'b1;
        tick_n(1);
        rst = 1'b0;
        chk("midrst_count", count_bcd, 8'h59);
        chk("midrst_running", running, 1'b0);
        chk("midrst_done", done, 1'b0);
        tick_n(8);
        chk("midrst_idle", count_bcd, 8'h59);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
